// File: rtl/result_serializer_pkg.sv
// Shared types and helpers for the systolic result serializer.
// Holds the stream FSM encoding and element narrowing logic.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } ser_state_t;

  localparam int NARROW_W = 64;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Values are carried at a fixed wide width; callers size-cast the result.
  function automatic logic [NARROW_W-1:0] narrow(
    input logic [NARROW_W-1:0] value,
    input int                  out_w,
    input bit                  sat
  );
    logic [NARROW_W-1:0] mask;
    if (out_w >= NARROW_W) begin
      mask = '1;
    end else begin
      mask = (NARROW_W'(1) << out_w) - NARROW_W'(1);
    end
    if (sat && ((value & ~mask) != '0)) begin
      return mask;
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Element stream bundle between the serializer and downstream store logic.
// Master drives valid/data/addr/last; slave returns ready.
interface result_serializer_if #(
  parameter int OUT_WIDTH = 8,
  parameter int IDX_W     = 2
);

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_addr;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/result_serializer_mem.sv
// Result RAM: one write port, one registered read port, async clear.
// A same-address read and write in one cycle returns the old word.
module result_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [AW-1:0]    ra_i,
  output logic [WIDTH-1:0] rd_o
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[wa_i] <= wd_i;
      end
      rd_q <= mem_q[ra_i];
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/result_serializer.sv
// Snapshots the systolic result grid and streams it element by element,
// in row- or column-major order, mirroring each accepted word into RAM.
module result_serializer
  import systolic_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  A_ROWS     = 2,
  parameter int  B_COLS     = 2,
  parameter int  OUT_WIDTH  = DATA_WIDTH,
  parameter int  SATURATE   = 1,
  localparam int IDX_W      = idx_width(A_ROWS * B_COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*DATA_WIDTH-1:0]   result [0:A_ROWS-1][0:B_COLS-1],
  input  logic                      start,
  input  logic                      col_major,
  result_serializer_if.master       out_if,
  output logic                      busy,
  output logic                      done,
  input  logic [IDX_W-1:0]          rd_addr,
  output logic [OUT_WIDTH-1:0]      rd_data
);

  localparam int ELEM_W = 2 * DATA_WIDTH;
  localparam int ROW_W  = idx_width(A_ROWS);
  localparam int COL_W  = idx_width(B_COLS);

  ser_state_t        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              cm_q, cm_d;
  logic [ELEM_W-1:0] snap_q [0:A_ROWS-1][0:B_COLS-1];

  logic              row_end;
  logic              col_end;
  logic              at_last;
  logic              hs;
  logic              cap;
  logic [ELEM_W-1:0] elem;

  assign row_end = (row_q == ROW_W'(A_ROWS - 1));
  assign col_end = (col_q == COL_W'(B_COLS - 1));
  assign at_last = row_end && col_end;
  assign elem    = snap_q[row_q][col_q];
  assign cap     = (state_q == S_IDLE) && start;

  // Outputs come only from registers, so ready never reaches valid/data.
  assign out_if.out_valid = (state_q == S_STREAM);
  assign out_if.out_last  = out_if.out_valid && at_last;
  assign out_if.out_data  =
    OUT_WIDTH'(narrow(NARROW_W'(elem), OUT_WIDTH, SATURATE != 0));
  assign out_if.out_addr  =
    IDX_W'(row_q) * IDX_W'(B_COLS) + IDX_W'(col_q);

  assign hs   = out_if.out_valid && out_if.out_ready;
  assign busy = (state_q == S_STREAM);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cm_d    = cm_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          row_d   = '0;
          col_d   = '0;
          cm_d    = col_major;
        end
      end
      S_STREAM: begin
        if (hs) begin
          if (at_last) begin
            state_d = S_DONE;
            row_d   = '0;
            col_d   = '0;
          end else if (!cm_q) begin
            if (col_end) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            if (row_end) begin
              row_d = '0;
              col_d = col_q + COL_W'(1);
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cm_q    <= cm_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < A_ROWS; r++) begin
        for (int c = 0; c < B_COLS; c++) begin
          snap_q[r][c] <= '0;
        end
      end
    end else if (cap) begin
      for (int r = 0; r < A_ROWS; r++) begin
        for (int c = 0; c < B_COLS; c++) begin
          snap_q[r][c] <= result[r][c];
        end
      end
    end
  end

  result_mem #(
    .DEPTH (A_ROWS * B_COLS),
    .WIDTH (OUT_WIDTH),
    .AW    (IDX_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we_i  (hs),
    .wa_i  (out_if.out_addr),
    .wd_i  (out_if.out_data),
    .ra_i  (rd_addr),
    .rd_o  (rd_data)
  );

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: two instances, saturating and
// truncating, share the grid, start and read-address stimulus.
module tb_result_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] res [0:1][0:1];
  logic        start;
  logic        col_major;
  logic [1:0]  rd_addr;
  logic        busy_a, done_a, busy_b, done_b;
  logic [7:0]  rd_a, rd_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  result_serializer_if #(.OUT_WIDTH(8), .IDX_W(2)) ifa ();
  result_serializer_if #(.OUT_WIDTH(8), .IDX_W(2)) ifb ();

  result_serializer #(
    .DATA_WIDTH(8), .A_ROWS(2), .B_COLS(2), .OUT_WIDTH(8), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .reset(reset), .result(res), .start(start),
    .col_major(col_major), .out_if(ifa), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr), .rd_data(rd_a)
  );

  result_serializer #(
    .DATA_WIDTH(8), .A_ROWS(2), .B_COLS(2), .OUT_WIDTH(8), .SATURATE(0)
  ) dut_trn (
    .clk(clk), .reset(reset), .result(res), .start(start),
    .col_major(col_major), .out_if(ifb), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr), .rd_data(rd_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mat(input logic [15:0] a, b, c, d);
    res[0][0] = a; res[0][1] = b; res[1][0] = c; res[1][1] = d;
  endtask

  task automatic set_ready(input logic r);
    ifa.out_ready = r;
    ifb.out_ready = r;
  endtask

  task automatic go(input logic cm);
    col_major = cm;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; col_major = 1'b0; rd_addr = 2'd0;
    set_ready(1'b0);
    set_mat(16'd0, 16'd0, 16'd0, 16'd0);
    step();
    nvec++; if (ifa.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", ifa.out_valid); end
    nvec++; if (ifa.out_last !== 1'b0) begin nerr++; $display("FAIL rst_last got %b want 0", ifa.out_last); end
    nvec++; if (busy_a !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy_a); end
    nvec++; if (done_a !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done_a); end
    nvec++; if (ifa.out_data !== 8'h00) begin nerr++; $display("FAIL rst_data got %h want 00", ifa.out_data); end
    nvec++; if (ifa.out_addr !== 2'd0) begin nerr++; $display("FAIL rst_addr got %0d want 0", ifa.out_addr); end
    nvec++; if (rd_a !== 8'h00) begin nerr++; $display("FAIL rst_rd got %h want 00", rd_a); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_row_major();
    logic [7:0] ed [4];
    ed = '{8'd1, 8'd2, 8'd3, 8'd4};
    set_mat(16'd1, 16'd2, 16'd3, 16'd4);
    set_ready(1'b1);
    go(1'b0);
    for (int k = 0; k < 4; k++) begin
      nvec++; if (ifa.out_valid !== 1'b1) begin nerr++; $display("FAIL rm_valid k=%0d got %b want 1", k, ifa.out_valid); end
      nvec++; if (busy_a !== 1'b1) begin nerr++; $display("FAIL rm_busy k=%0d got %b want 1", k, busy_a); end
      nvec++; if (ifa.out_data !== ed[k]) begin nerr++; $display("FAIL rm_data k=%0d got %h want %h", k, ifa.out_data, ed[k]); end
      nvec++; if (ifb.out_data !== ed[k]) begin nerr++; $display("FAIL rm_data_trn k=%0d got %h want %h", k, ifb.out_data, ed[k]); end
      nvec++; if (ifa.out_addr !== 2'(k)) begin nerr++; $display("FAIL rm_addr k=%0d got %0d want %0d", k, ifa.out_addr, k); end
      nvec++; if (ifa.out_last !== (k == 3)) begin nerr++; $display("FAIL rm_last k=%0d got %b want %b", k, ifa.out_last, k == 3); end
      step();
    end
    nvec++; if (done_a !== 1'b1) begin nerr++; $display("FAIL rm_done got %b want 1", done_a); end
    nvec++; if (busy_a !== 1'b0) begin nerr++; $display("FAIL rm_busy_done got %b want 0", busy_a); end
    nvec++; if (ifa.out_valid !== 1'b0) begin nerr++; $display("FAIL rm_valid_done got %b want 0", ifa.out_valid); end
    step();
    nvec++; if (done_a !== 1'b0) begin nerr++; $display("FAIL rm_done_pulse got %b want 0", done_a); end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      step();
      nvec++; if (rd_a !== ed[k]) begin nerr++; $display("FAIL rm_mem a=%0d got %h want %h", k, rd_a, ed[k]); end
    end
  endtask

  task automatic test_col_major();
    logic [7:0] ed [4];
    logic [1:0] ea [4];
    logic [7:0] em [4];
    ed = '{8'd5, 8'd7, 8'd6, 8'd8};
    ea = '{2'd0, 2'd2, 2'd1, 2'd3};
    em = '{8'd5, 8'd6, 8'd7, 8'd8};
    set_mat(16'd5, 16'd6, 16'd7, 16'd8);
    set_ready(1'b1);
    go(1'b1);
    for (int k = 0; k < 4; k++) begin
      nvec++; if (ifa.out_data !== ed[k]) begin nerr++; $display("FAIL cm_data k=%0d got %h want %h", k, ifa.out_data, ed[k]); end
      nvec++; if (ifa.out_addr !== ea[k]) begin nerr++; $display("FAIL cm_addr k=%0d got %0d want %0d", k, ifa.out_addr, ea[k]); end
      nvec++; if (ifa.out_last !== (k == 3)) begin nerr++; $display("FAIL cm_last k=%0d got %b want %b", k, ifa.out_last, k == 3); end
      step();
    end
    nvec++; if (done_a !== 1'b1) begin nerr++; $display("FAIL cm_done got %b want 1", done_a); end
    step();
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      step();
      nvec++; if (rd_a !== em[k]) begin nerr++; $display("FAIL cm_mem a=%0d got %h want %h", k, rd_a, em[k]); end
    end
  endtask

  task automatic test_narrow();
    logic [7:0] es [4];
    logic [7:0] et [4];
    es = '{8'hFF, 8'h42, 8'hFF, 8'hFF};
    et = '{8'hF4, 8'h42, 8'h00, 8'hFF};
    set_mat(16'h01F4, 16'h0042, 16'h0100, 16'h00FF);
    set_ready(1'b1);
    go(1'b0);
    for (int k = 0; k < 4; k++) begin
      nvec++; if (ifa.out_data !== es[k]) begin nerr++; $display("FAIL sat_data k=%0d got %h want %h", k, ifa.out_data, es[k]); end
      nvec++; if (ifb.out_data !== et[k]) begin nerr++; $display("FAIL trn_data k=%0d got %h want %h", k, ifb.out_data, et[k]); end
      nvec++; if (busy_b !== 1'b1) begin nerr++; $display("FAIL trn_busy k=%0d got %b want 1", k, busy_b); end
      step();
    end
    nvec++; if (done_b !== 1'b1) begin nerr++; $display("FAIL trn_done got %b want 1", done_b); end
    step();
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      step();
      nvec++; if (rd_a !== es[k]) begin nerr++; $display("FAIL sat_mem a=%0d got %h want %h", k, rd_a, es[k]); end
      nvec++; if (rd_b !== et[k]) begin nerr++; $display("FAIL trn_mem a=%0d got %h want %h", k, rd_b, et[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [4];
    logic [7:0] e;
    int hs = 0;
    int dones = 0;
    int c = 0;
    ed = '{8'h15, 8'h16, 8'h17, 8'h18};
    set_mat(16'h15, 16'h16, 16'h17, 16'h18);
    set_ready(1'b0);
    go(1'b0);
    while (c < 40 && dones == 0) begin
      if (done_a) begin
        dones++;
      end else begin
        set_ready(c % 3 == 0);
        e = (hs < 4) ? ed[hs] : 8'h00;
        nvec++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== e) begin nerr++; $display("FAIL bp_data c=%0d got %h v=%b want %h", c, ifa.out_data, ifa.out_valid, e); end
        nvec++; if (ifa.out_addr !== 2'(hs)) begin nerr++; $display("FAIL bp_addr c=%0d got %0d want %0d", c, ifa.out_addr, hs); end
        nvec++; if (ifa.out_last !== (hs == 3)) begin nerr++; $display("FAIL bp_last c=%0d got %b want %b", c, ifa.out_last, hs == 3); end
        if (ifa.out_valid && ifa.out_ready) hs++;
        step();
        c++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (done_a) dones++;
    end
    nvec++; if (hs != 4) begin nerr++; $display("FAIL bp_handshakes got %0d want 4", hs); end
    nvec++; if (dones != 1) begin nerr++; $display("FAIL bp_done_count got %0d want 1", dones); end
  endtask

  task automatic test_ignored_start();
    logic [7:0] ed [4];
    ed = '{8'd9, 8'd10, 8'd11, 8'd12};
    set_mat(16'd9, 16'd10, 16'd11, 16'd12);
    set_ready(1'b1);
    go(1'b0);
    for (int k = 0; k < 4; k++) begin
      nvec++; if (ifa.out_data !== ed[k]) begin nerr++; $display("FAIL ign_data k=%0d got %h want %h", k, ifa.out_data, ed[k]); end
      nvec++; if (ifa.out_addr !== 2'(k)) begin nerr++; $display("FAIL ign_addr k=%0d got %0d want %0d", k, ifa.out_addr, k); end
      if (k == 1) begin
        start = 1'b1;
        set_mat(16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD);
      end
      if (k == 2) start = 1'b0;
      step();
    end
    nvec++; if (done_a !== 1'b1) begin nerr++; $display("FAIL ign_done got %b want 1", done_a); end
    for (int k = 0; k < 3; k++) begin
      step();
      nvec++; if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0) begin nerr++; $display("FAIL ign_restart k=%0d got v=%b b=%b want 0", k, ifa.out_valid, busy_a); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ed [4];
    ed = '{8'd13, 8'd14, 8'd15, 8'd16};
    set_mat(16'd1, 16'd2, 16'd3, 16'd4);
    set_ready(1'b1);
    rd_addr = 2'd0;
    go(1'b0);
    step();
    step();
    nvec++; if (ifa.out_data !== 8'd3) begin nerr++; $display("FAIL rmid_pre got %h want 03", ifa.out_data); end
    reset = 1'b1;
    #1;
    nvec++; if (ifa.out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got %b want 0", ifa.out_valid); end
    nvec++; if (ifa.out_data !== 8'h00) begin nerr++; $display("FAIL rmid_data got %h want 00", ifa.out_data); end
    nvec++; if (ifa.out_addr !== 2'd0) begin nerr++; $display("FAIL rmid_addr got %0d want 0", ifa.out_addr); end
    nvec++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin nerr++; $display("FAIL rmid_status got b=%b d=%b want 0", busy_a, done_a); end
    nvec++; if (rd_a !== 8'h00) begin nerr++; $display("FAIL rmid_rd got %h want 00", rd_a); end
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      step();
      nvec++; if (rd_a !== 8'h00 || done_a !== 1'b0) begin nerr++; $display("FAIL rmid_mem a=%0d got %h d=%b want 00", k, rd_a, done_a); end
    end
    set_mat(16'd13, 16'd14, 16'd15, 16'd16);
    go(1'b0);
    for (int k = 0; k < 4; k++) begin
      nvec++; if (ifa.out_data !== ed[k]) begin nerr++; $display("FAIL rmid_new k=%0d got %h want %h", k, ifa.out_data, ed[k]); end
      nvec++; if (ifa.out_addr !== 2'(k)) begin nerr++; $display("FAIL rmid_naddr k=%0d got %0d want %0d", k, ifa.out_addr, k); end
      step();
    end
    nvec++; if (done_a !== 1'b1) begin nerr++; $display("FAIL rmid_done got %b want 1", done_a); end
    step();
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_narrow();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
